mke_host_link: RTL and testbench

Host-side MKE command/status link for the CDTV drive emulator. It sits between the CDTV data bus (DATA_BUS, HWR, HRD, CMD, ENABLE) and the Pi-facing command logic. It assembles opcode and parameter bytes written by the host into complete command packets and hands them over with a valid/ready handshake. It also returns status bytes to the host from a 16-entry FIFO, and drives STEN and STCH.

---
 rtl/mke_host_link.sv | 233 +++++++++++++++++++++++
 tb/tb_mke_host_link.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mke_host_link.sv
// mke_host_link: CDTV host bus side of the MKE command/status link.
// Builds command packets from host writes and serves status bytes to host reads.
module mke_host_link #(
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int STCH_WIDTH     = 200
) (
    input  logic        PI_CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        HWR,
    input  logic        HRD,
    input  logic        CMD,
    input  logic [7:0]  DATA_BUS_I,
    output logic [7:0]  DATA_BUS_O,
    output logic        DATA_BUS_OE,
    output logic        DIR_BI,
    output logic        STEN,
    output logic        STCH,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [47:0] cmd_params,
    output logic [2:0]  cmd_len,
    output logic        cmd_bad,
    output logic        cmd_abort,
    input  logic        stat_valid,
    input  logic [7:0]  stat_data,
    output logic        stat_ready
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STCH_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, PARAM, HOLD} state_t;

    logic [11:0] sync1, sync2;
    logic        hwr_s, hrd_s, cmd_s, en_s;
    logic [7:0]  din_s;

    logic        hwr_q, hrd_q, cmd_lat, take;
    logic [7:0]  data_lat, take_byte;
    logic        hwr_rise, hrd_rise;

    state_t      state, state_n;
    logic [TW-1:0] timer;
    logic [2:0]  idx, len_q, lk_len;
    logic        bad_q, lk_bad, timeout;
    logic [7:0]  opcode_q;
    logic [47:0] params_q;

    logic [7:0]  mem [16];
    logic [3:0]  wptr, rptr;
    logic [4:0]  count;
    logic        push, pop, rd_drive, oe_q, sten_q;
    logic [7:0]  dout_q;
    logic [SW-1:0] stch_cnt;

    // Strobes, CMD, ENABLE and data share one synchroniser so they stay aligned
    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            sync1 <= 12'hC00;
            sync2 <= 12'hC00;
        end else begin
            sync1 <= {HWR, HRD, CMD, ENABLE, DATA_BUS_I};
            sync2 <= sync1;
        end
    end

    assign {hwr_s, hrd_s, cmd_s, en_s, din_s} = sync2;
    assign hwr_rise = hwr_s & ~hwr_q;
    assign hrd_rise = hrd_s & ~hrd_q;

    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            hwr_q     <= 1'b1;
            hrd_q     <= 1'b1;
            cmd_lat   <= 1'b0;
            data_lat  <= 8'h00;
            take      <= 1'b0;
            take_byte <= 8'h00;
        end else begin
            hwr_q <= hwr_s;
            hrd_q <= hrd_s;
            if (!hwr_s)
                data_lat <= din_s;
            if (!hwr_s || !hrd_s)
                cmd_lat <= cmd_s;
            take      <= hwr_rise & en_s & cmd_lat;
            take_byte <= data_lat;
        end
    end

    function automatic logic [3:0] lookup(input logic [7:0] op);
        case (op)
            8'h01, 8'h0b:                   return 4'd4;
            8'h02, 8'h09, 8'h0a:            return 4'd6;
            8'h84, 8'h8a:                   return 4'd2;
            8'h8b, 8'ha3:                   return 4'd1;
            8'h04, 8'h05, 8'h81, 8'h82,
            8'h83, 8'h87, 8'h89:            return 4'd0;
            default:                        return 4'b1000;
        endcase
    endfunction

    assign {lk_bad, lk_len} = lookup(take_byte);
    assign timeout = (state == PARAM) && !take
                   && (timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:
                if (take)
                    state_n = (lk_len == 3'd0) ? HOLD : PARAM;
            PARAM:
                if (take && (idx + 3'd1 == len_q))
                    state_n = HOLD;
                else if (timeout)
                    state_n = IDLE;
            HOLD:
                if (cmd_ready)
                    state_n = IDLE;
            default:
                state_n = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == HOLD);
        cmd_abort = timeout | ((state == HOLD) & take);
    end

    // Params were cleared with the opcode, so each byte can be OR-ed into place
    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            opcode_q <= 8'h00;
            params_q <= 48'h0;
            len_q    <= 3'd0;
            bad_q    <= 1'b0;
            idx      <= 3'd0;
            timer    <= '0;
        end else if (state == IDLE) begin
            timer <= '0;
            if (take) begin
                opcode_q <= take_byte;
                params_q <= 48'h0;
                len_q    <= lk_len;
                bad_q    <= lk_bad;
                idx      <= 3'd0;
            end
        end else if (state == PARAM) begin
            if (take) begin
                params_q <= params_q | ({take_byte, 40'h0} >> {idx, 3'b000});
                idx      <= idx + 3'd1;
                timer    <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
        end
    end

    assign cmd_opcode = opcode_q;
    assign cmd_params = params_q;
    assign cmd_len    = len_q;
    assign cmd_bad    = bad_q;

    assign stat_ready = (count != 5'd16);
    assign push       = stat_valid & stat_ready;
    assign pop        = hrd_rise & en_s & cmd_lat & (count != 5'd0);
    assign rd_drive   = ~hrd_s & en_s & cmd_s;

    always_ff @(posedge PI_CLK) begin
        if (push)
            mem[wptr] <= stat_data;
    end

    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            wptr  <= 4'd0;
            rptr  <= 4'd0;
            count <= 5'd0;
        end else begin
            if (push)
                wptr <= wptr + 4'd1;
            if (pop)
                rptr <= rptr + 4'd1;
            unique case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            oe_q   <= 1'b0;
            dout_q <= 8'hFF;
        end else begin
            oe_q   <= rd_drive;
            dout_q <= (rd_drive && count != 5'd0) ? mem[rptr] : 8'hFF;
        end
    end

    assign DATA_BUS_O  = dout_q;
    assign DATA_BUS_OE = oe_q;
    assign DIR_BI      = oe_q;

    // A fresh empty-to-nonempty transition reloads the pulse width
    always_ff @(posedge PI_CLK or posedge RESET) begin
        if (RESET) begin
            sten_q   <= 1'b0;
            stch_cnt <= '0;
        end else begin
            sten_q <= (count != 5'd0);
            if (count != 5'd0 && !sten_q)
                stch_cnt <= SW'(STCH_WIDTH);
            else if (stch_cnt != '0)
                stch_cnt <= stch_cnt - SW'(1);
        end
    end

    assign STEN = sten_q;
    assign STCH = (stch_cnt != '0);

endmodule

// File: tb/tb_mke_host_link.sv
// tb_mke_host_link: directed bench for the MKE host link.
// Drives the host bus at negedges and compares against hand-computed values.
module tb_mke_host_link;

    logic        PI_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        HWR = 1'b1;
    logic        HRD = 1'b1;
    logic        CMD = 1'b0;
    logic [7:0]  DATA_BUS_I = 8'h00;
    logic [7:0]  DATA_BUS_O;
    logic        DATA_BUS_OE;
    logic        DIR_BI;
    logic        STEN;
    logic        STCH;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [7:0]  cmd_opcode;
    logic [47:0] cmd_params;
    logic [2:0]  cmd_len;
    logic        cmd_bad;
    logic        cmd_abort;
    logic        stat_valid = 1'b0;
    logic [7:0]  stat_data = 8'h00;
    logic        stat_ready;

    mke_host_link #(
        .TIMEOUT_CYCLES(1000),
        .STCH_WIDTH(200)
    ) dut (
        .PI_CLK(PI_CLK),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .HWR(HWR),
        .HRD(HRD),
        .CMD(CMD),
        .DATA_BUS_I(DATA_BUS_I),
        .DATA_BUS_O(DATA_BUS_O),
        .DATA_BUS_OE(DATA_BUS_OE),
        .DIR_BI(DIR_BI),
        .STEN(STEN),
        .STCH(STCH),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_params(cmd_params),
        .cmd_len(cmd_len),
        .cmd_bad(cmd_bad),
        .cmd_abort(cmd_abort),
        .stat_valid(stat_valid),
        .stat_data(stat_data),
        .stat_ready(stat_ready)
    );

    always #5 PI_CLK = ~PI_CLK;

    int n_chk = 0;
    int n_pass = 0;
    int abort_cnt = 0;
    int stch_hi = 0;
    int snap;
    logic [7:0] d;
    logic oe;
    bit stable;

    always @(posedge PI_CLK) begin
        if (cmd_abort) abort_cnt++;
        if (STCH) stch_hi++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit en, input bit lat);
        DATA_BUS_I = b;
        CMD = 1'b1;
        ENABLE = en;
        HWR = 1'b0;
        repeat (4) @(negedge PI_CLK);
        HWR = 1'b1;
        repeat (3) @(negedge PI_CLK);
        if (lat) check("valid_edge3", cmd_valid, 0);
        @(negedge PI_CLK);
        ENABLE = 1'b1;
    endtask

    task automatic rd_byte(output logic [7:0] v, output logic o);
        CMD = 1'b1;
        HRD = 1'b0;
        repeat (4) @(negedge PI_CLK);
        v = DATA_BUS_O;
        o = DATA_BUS_OE & DIR_BI;
        HRD = 1'b1;
        repeat (4) @(negedge PI_CLK);
    endtask

    task automatic push(input logic [7:0] v);
        stat_valid = 1'b1;
        stat_data = v;
        @(negedge PI_CLK);
        stat_valid = 1'b0;
    endtask

    task automatic handshake();
        cmd_ready = 1'b1;
        @(negedge PI_CLK);
        cmd_ready = 1'b0;
        check("valid_after_hs", cmd_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge PI_CLK);
        check("rst_dout", DATA_BUS_O, 8'hFF);
        check("rst_oe", DATA_BUS_OE, 0);
        check("rst_dir", DIR_BI, 0);
        check("rst_sten", STEN, 0);
        check("rst_stch", STCH, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_opcode", cmd_opcode, 0);
        check("rst_params", cmd_params, 0);
        check("rst_len", cmd_len, 0);
        check("rst_bad", cmd_bad, 0);
        check("rst_abort", cmd_abort, 0);
        check("rst_ready", stat_ready, 1);
        RESET = 1'b0;
        ENABLE = 1'b1;
        @(negedge PI_CLK);

        // six-parameter command
        wr_byte(8'h0a, 1, 0);
        wr_byte(8'h00, 1, 0);
        wr_byte(8'h00, 1, 0);
        wr_byte(8'h02, 1, 0);
        wr_byte(8'h00, 1, 0);
        wr_byte(8'h10, 1, 0);
        wr_byte(8'h20, 1, 1);
        check("c0a_valid", cmd_valid, 1);
        check("c0a_opcode", cmd_opcode, 8'h0a);
        check("c0a_params", cmd_params, 48'h000002001020);
        check("c0a_len", cmd_len, 6);
        check("c0a_bad", cmd_bad, 0);
        handshake();

        // held packet with consumer stalled
        wr_byte(8'h81, 1, 1);
        stable = 1'b1;
        repeat (100) begin
            if (!(cmd_valid && cmd_opcode == 8'h81 && cmd_len == 3'd0))
                stable = 1'b0;
            @(negedge PI_CLK);
        end
        check("c81_hold100", stable, 1);
        check("c81_len", cmd_len, 0);
        handshake();

        // inter-byte timeout
        snap = abort_cnt;
        wr_byte(8'h01, 1, 0);
        wr_byte(8'h00, 1, 0);
        repeat (1010) @(negedge PI_CLK);
        check("to_aborts", abort_cnt - snap, 1);
        check("to_novalid", cmd_valid, 0);
        wr_byte(8'h82, 1, 0);
        check("c82_valid", cmd_valid, 1);
        check("c82_opcode", cmd_opcode, 8'h82);
        check("c82_len", cmd_len, 0);
        handshake();

        // unknown opcode, then bytes written while it is held
        wr_byte(8'h55, 1, 0);
        check("c55_valid", cmd_valid, 1);
        check("c55_bad", cmd_bad, 1);
        check("c55_len", cmd_len, 0);
        snap = abort_cnt;
        wr_byte(8'h84, 1, 0);
        wr_byte(8'h01, 1, 0);
        check("hold_aborts", abort_cnt - snap, 2);
        check("hold_opcode", cmd_opcode, 8'h55);
        check("hold_bad", cmd_bad, 1);
        check("hold_params", cmd_params, 0);
        check("hold_valid", cmd_valid, 1);
        handshake();

        // writes ignored while deselected
        wr_byte(8'h81, 0, 0);
        repeat (5) @(negedge PI_CLK);
        check("dis_valid", cmd_valid, 0);

        // status path and STCH width
        snap = stch_hi;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        check("st_sten", STEN, 1);
        repeat (300) @(negedge PI_CLK);
        check("stch_width", stch_hi - snap, 200);
        check("stch_low", STCH, 0);
        rd_byte(d, oe);
        check("rd1", d, 8'h11);
        check("rd1_oe", oe, 1);
        rd_byte(d, oe);
        check("rd2", d, 8'h22);
        rd_byte(d, oe);
        check("rd3", d, 8'h33);
        check("st_sten_off", STEN, 0);
        rd_byte(d, oe);
        check("rd_empty", d, 8'hFF);

        // fill past full
        stat_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            stat_data = 8'h40 + 8'(i);
            @(negedge PI_CLK);
        end
        stat_valid = 1'b0;
        check("full_ready", stat_ready, 0);
        rd_byte(d, oe);
        check("full_rd0", d, 8'h40);
        check("ready_15", stat_ready, 1);

        // push lands on the pop edge
        CMD = 1'b1;
        HRD = 1'b0;
        repeat (4) @(negedge PI_CLK);
        d = DATA_BUS_O;
        HRD = 1'b1;
        repeat (2) @(negedge PI_CLK);
        push(8'hA0);
        @(negedge PI_CLK);
        check("pp_rd", d, 8'h41);
        check("pp_ready", stat_ready, 1);
        push(8'hA1);
        check("pp_full", stat_ready, 0);
        for (int i = 0; i < 14; i++) begin
            rd_byte(d, oe);
            check("drain", d, 8'h42 + 8'(i));
        end
        rd_byte(d, oe);
        check("drain_a0", d, 8'hA0);
        rd_byte(d, oe);
        check("drain_a1", d, 8'hA1);
        check("drain_sten", STEN, 0);

        // reset releases the bus mid-read
        CMD = 1'b1;
        HRD = 1'b0;
        repeat (4) @(negedge PI_CLK);
        check("mr_oe", DATA_BUS_OE, 1);
        RESET = 1'b1;
        #1;
        check("mr_oe_rst", DATA_BUS_OE, 0);
        check("mr_dir_rst", DIR_BI, 0);
        HRD = 1'b1;
        @(negedge PI_CLK);
        RESET = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
